// File: rtl/rot_pkg.sv
// Shared definitions for the rotate engine: controller state encoding,
// job error codes, image limits and the 8x8 set-count helpers.
// Intended for reuse by rot_job_ctrl and core_set.
package rot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_FINISH = 3'd4
    } rot_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BADCFG  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    localparam int MAX_H   = 32767;
    localparam int MAX_W   = 16383;
    localparam int SET_DIM = 8;

    // MAX_H / MAX_W bounds are the same test as H[15]==0 and W[15:14]==0.
    function automatic logic cfg_valid(input logic [15:0] h,
                                       input logic [15:0] w,
                                       input logic [2:0]  deg);
        return (h != 16'd0) && (w != 16'd0) &&
               (h <= 16'(MAX_H)) && (w <= 16'(MAX_W)) && (deg <= 3'd3);
    endfunction

    // Number of 8-pixel sets covering a dimension, rounded up.
    function automatic logic [12:0] sets_h(input logic [15:0] dim);
        return 13'(({1'b0, dim} + 17'(SET_DIM - 1)) >> 3);
    endfunction

    function automatic logic [11:0] sets_w(input logic [15:0] dim);
        return 12'(({1'b0, dim} + 17'(SET_DIM - 1)) >> 3);
    endfunction

endpackage

// File: rtl/rot_set_mul.sv
// Sequential shift-add multiplier, 13x12 -> 24 bits.
// The first partial product is taken on the I_GO edge, the remaining
// eleven on the following edges, so O_VALID pulses 12 cycles after I_GO.
// Ports: I_HCLK, I_HRESET_N (async, active-low), I_GO start pulse,
//        I_A/I_B operands, O_P product (stable while O_VALID), O_VALID pulse.
module rot_set_mul (
    input  logic        I_HCLK,
    input  logic        I_HRESET_N,
    input  logic        I_GO,
    input  logic [12:0] I_A,
    input  logic [11:0] I_B,
    output logic [23:0] O_P,
    output logic        O_VALID
);

    logic [23:0] acc;
    logic [23:0] mcand;
    logic [11:0] mplier;
    logic [3:0]  cnt;

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            acc     <= 24'd0;
            mcand   <= 24'd0;
            mplier  <= 12'd0;
            cnt     <= 4'd0;
            O_VALID <= 1'b0;
        end else if (I_GO) begin
            acc     <= I_B[0] ? {11'd0, I_A} : 24'd0;
            mcand   <= {10'd0, I_A, 1'b0};
            mplier  <= {1'b0, I_B[11:1]};
            cnt     <= 4'd11;
            O_VALID <= 1'b0;
        end else if (cnt != 4'd0) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt - 4'd1;
            O_VALID <= (cnt == 4'd1);
        end else begin
            O_VALID <= 1'b0;
        end
    end

    assign O_P = acc;

endmodule

// File: rtl/rot_job_ctrl.sv
// Job-level sequencer for the rotate engine.
// Validates and latches the job configuration, computes the number of 8x8
// sets, launches the core, counts set completions, supervises DMA stalls
// and reports completion/error through sticky status and interrupt.
// Ports: I_HCLK/I_HRESET_N clock and async active-low reset; I_CFG_* job
//        configuration and start/abort pulses; I_IRQ_CLR; I_CORE_BUSY,
//        I_CORE_SET_DONE, I_DMA_READY from the core side; O_CORE_* launch,
//        abort and latched configuration; O_BUSY, O_DONE, O_ERR, O_IRQ,
//        O_SETS_LEFT status.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | no job; waits for a start with a valid configuration
// ST_CALC   | multiplier running hsets*wsets (12 cycles)
// ST_LAUNCH | O_CORE_START high for this one cycle
// ST_RUN    | counting set completions, DMA watchdog active
// ST_FINISH | all sets written, waiting for the core to go idle
module rot_job_ctrl
    import rot_pkg::*;
#(
    parameter int TIMEOUT_W = 16,
    parameter int SETS_W    = 24
) (
    input  logic              I_HCLK,
    input  logic              I_HRESET_N,
    input  logic [15:0]       I_CFG_HEIGHT,
    input  logic [15:0]       I_CFG_WIDTH,
    input  logic              I_CFG_DIRECTION,
    input  logic [2:0]        I_CFG_DEGREES,
    input  logic              I_CFG_START,
    input  logic              I_CFG_ABORT,
    input  logic              I_IRQ_CLR,
    input  logic              I_CORE_BUSY,
    input  logic              I_CORE_SET_DONE,
    input  logic              I_DMA_READY,
    output logic              O_CORE_START,
    output logic [15:0]       O_CORE_HEIGHT,
    output logic [15:0]       O_CORE_WIDTH,
    output logic              O_CORE_DIRECTION,
    output logic [2:0]        O_CORE_DEGREES,
    output logic              O_CORE_ABORT,
    output logic              O_BUSY,
    output logic              O_DONE,
    output logic [1:0]        O_ERR,
    output logic              O_IRQ,
    output logic [SETS_W-1:0] O_SETS_LEFT
);

    // The increment that would land the watchdog on all-ones is the one
    // that fires, i.e. 2^TIMEOUT_W-1 consecutive stalled cycles.
    localparam logic [TIMEOUT_W-1:0] WD_FIRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    rot_state_t           state, state_nxt;
    logic [TIMEOUT_W-1:0] wd, wd_nxt;
    logic                 mul_go, mul_go_nxt;
    logic [23:0]          mul_p;
    logic                 mul_valid;

    logic              core_start_nxt, core_abort_nxt, busy_nxt, done_nxt;
    logic              irq_set, dir_nxt;
    logic [1:0]        err_nxt;
    logic [15:0]       height_nxt, width_nxt;
    logic [2:0]        deg_nxt;
    logic [SETS_W-1:0] sets_nxt;
    logic              last_set;

    rot_set_mul u_mul (
        .I_HCLK     (I_HCLK),
        .I_HRESET_N (I_HRESET_N),
        .I_GO       (mul_go),
        .I_A        (sets_h(O_CORE_HEIGHT)),
        .I_B        (sets_w(O_CORE_WIDTH)),
        .O_P        (mul_p),
        .O_VALID    (mul_valid)
    );

    always_comb begin
        state_nxt      = state;
        wd_nxt         = '0;
        mul_go_nxt     = 1'b0;
        core_start_nxt = 1'b0;
        core_abort_nxt = 1'b0;
        busy_nxt       = O_BUSY;
        done_nxt       = O_DONE;
        err_nxt        = O_ERR;
        irq_set        = 1'b0;
        height_nxt     = O_CORE_HEIGHT;
        width_nxt      = O_CORE_WIDTH;
        dir_nxt        = O_CORE_DIRECTION;
        deg_nxt        = O_CORE_DEGREES;
        sets_nxt       = O_SETS_LEFT;
        last_set       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (I_CFG_START && !I_CFG_ABORT) begin
                    done_nxt   = 1'b0;
                    height_nxt = I_CFG_HEIGHT;
                    width_nxt  = I_CFG_WIDTH;
                    dir_nxt    = I_CFG_DIRECTION;
                    deg_nxt    = I_CFG_DEGREES;
                    if (cfg_valid(I_CFG_HEIGHT, I_CFG_WIDTH, I_CFG_DEGREES)) begin
                        err_nxt    = ERR_NONE;
                        busy_nxt   = 1'b1;
                        mul_go_nxt = 1'b1;
                        state_nxt  = ST_CALC;
                    end else begin
                        err_nxt = ERR_BADCFG;
                        irq_set = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                // A valid seen alongside GO belongs to an earlier, aborted job.
                if (mul_valid && !mul_go) begin
                    sets_nxt       = SETS_W'(mul_p);
                    core_start_nxt = 1'b1;
                    state_nxt      = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (I_CORE_SET_DONE && O_SETS_LEFT != '0) begin
                    sets_nxt = O_SETS_LEFT - 1'b1;
                    last_set = (O_SETS_LEFT == SETS_W'(1));
                end
                if (last_set) begin
                    state_nxt = ST_FINISH;
                end else if (!I_DMA_READY && wd == WD_FIRE) begin
                    err_nxt        = ERR_TIMEOUT;
                    core_abort_nxt = 1'b1;
                    irq_set        = 1'b1;
                    busy_nxt       = 1'b0;
                    state_nxt      = ST_IDLE;
                end else if (!I_DMA_READY) begin
                    wd_nxt = wd + 1'b1;
                end
            end
            ST_FINISH: begin
                if (!I_CORE_BUSY) begin
                    done_nxt  = 1'b1;
                    irq_set   = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        // Abort overrides everything the active states decided this cycle.
        if (state != ST_IDLE && I_CFG_ABORT) begin
            state_nxt      = ST_IDLE;
            wd_nxt         = '0;
            core_start_nxt = 1'b0;
            core_abort_nxt = 1'b1;
            busy_nxt       = 1'b0;
            done_nxt       = 1'b0;
            err_nxt        = ERR_ABORT;
            irq_set        = 1'b1;
            sets_nxt       = '0;
        end
    end

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            state            <= ST_IDLE;
            wd               <= '0;
            mul_go           <= 1'b0;
            O_CORE_START     <= 1'b0;
            O_CORE_ABORT     <= 1'b0;
            O_CORE_HEIGHT    <= 16'd0;
            O_CORE_WIDTH     <= 16'd0;
            O_CORE_DIRECTION <= 1'b0;
            O_CORE_DEGREES   <= 3'd0;
            O_BUSY           <= 1'b0;
            O_DONE           <= 1'b0;
            O_ERR            <= ERR_NONE;
            O_IRQ            <= 1'b0;
            O_SETS_LEFT      <= '0;
        end else begin
            state            <= state_nxt;
            wd               <= wd_nxt;
            mul_go           <= mul_go_nxt;
            O_CORE_START     <= core_start_nxt;
            O_CORE_ABORT     <= core_abort_nxt;
            O_CORE_HEIGHT    <= height_nxt;
            O_CORE_WIDTH     <= width_nxt;
            O_CORE_DIRECTION <= dir_nxt;
            O_CORE_DEGREES   <= deg_nxt;
            O_BUSY           <= busy_nxt;
            O_DONE           <= done_nxt;
            O_ERR            <= err_nxt;
            // A set event wins over a simultaneous clear.
            O_IRQ            <= irq_set ? 1'b1 : (I_IRQ_CLR ? 1'b0 : O_IRQ);
            O_SETS_LEFT      <= sets_nxt;
        end
    end

endmodule

// File: tb/tb_rot_job_ctrl.sv
// Self-checking bench for rot_job_ctrl (watchdog width reduced to 4 bits).
module tb_rot_job_ctrl;

    localparam int TW = 4;
    localparam int SW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   cfg_h = '0, cfg_w = '0;
    logic          cfg_dir = 1'b0;
    logic [2:0]    cfg_deg = '0;
    logic          start = 1'b0, abort = 1'b0, irq_clr = 1'b0;
    logic          core_busy = 1'b0, set_done = 1'b0, dma_ready = 1'b1;
    logic          core_start, core_dir, core_abort, busy, done, irq;
    logic [15:0]   core_h, core_w;
    logic [2:0]    core_deg;
    logic [1:0]    err;
    logic [SW-1:0] sets_left;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rot_job_ctrl #(.TIMEOUT_W(TW), .SETS_W(SW)) dut (
        .I_HCLK          (clk),
        .I_HRESET_N      (rst_n),
        .I_CFG_HEIGHT    (cfg_h),
        .I_CFG_WIDTH     (cfg_w),
        .I_CFG_DIRECTION (cfg_dir),
        .I_CFG_DEGREES   (cfg_deg),
        .I_CFG_START     (start),
        .I_CFG_ABORT     (abort),
        .I_IRQ_CLR       (irq_clr),
        .I_CORE_BUSY     (core_busy),
        .I_CORE_SET_DONE (set_done),
        .I_DMA_READY     (dma_ready),
        .O_CORE_START    (core_start),
        .O_CORE_HEIGHT   (core_h),
        .O_CORE_WIDTH    (core_w),
        .O_CORE_DIRECTION(core_dir),
        .O_CORE_DEGREES  (core_deg),
        .O_CORE_ABORT    (core_abort),
        .O_BUSY          (busy),
        .O_DONE          (done),
        .O_ERR           (err),
        .O_IRQ           (irq),
        .O_SETS_LEFT     (sets_left)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: sets = ceil(H/8) * ceil(W/8).
    function automatic int exp_sets(input int h, input int w);
        return ((h + 7) / 8) * ((w + 7) / 8);
    endfunction

    function automatic bit exp_valid(input int h, input int w, input int deg);
        return h >= 1 && h <= 32767 && w >= 1 && w <= 16383 && deg <= 3;
    endfunction

    task automatic drive_cfg(input int h, input int w, input int deg, input int dir);
        cfg_h   = h[15:0];
        cfg_w   = w[15:0];
        cfg_deg = deg[2:0];
        cfg_dir = dir[0];
    endtask

    // Starts a valid job; returns once the controller is in its counting phase.
    task automatic start_job(input int h, input int w, input int deg, input int dir);
        int lat;
        drive_cfg(h, w, deg, dir);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("err_cleared_on_start", 32'(err), 0);
        lat = 0;
        for (int e = 1; e <= 40 && !core_start; e++) begin
            tick();
            lat = e;
        end
        chk("start_latency", 32'(lat), 13);
        chk("sets_loaded", 32'(sets_left), 32'(exp_sets(h, w)));
        chk("cfg_height", 32'(core_h), 32'(h));
        chk("cfg_width", 32'(core_w), 32'(w));
        chk("cfg_deg", 32'(core_deg), 32'(deg));
        chk("cfg_dir", 32'(core_dir), 32'(dir & 1));
        core_busy = 1'b1;
        tick();
        chk("core_start_single", 32'(core_start), 0);
    endtask

    task automatic send_sets(input int count, inout int left);
        for (int i = 0; i < count; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                dma_ready = 1'($urandom_range(0, 1));
                tick();
            end
            dma_ready = 1'b1;
            set_done  = 1'b1;
            tick();
            set_done = 1'b0;
            left--;
            chk("sets_dec", 32'(sets_left), 32'(left));
            chk("busy_running", 32'(busy), 1);
        end
    endtask

    task automatic finish_job(input int n, input bit clr_same);
        int left, hold;
        left = n;
        send_sets(n, left);
        hold = $urandom_range(0, 4);
        repeat (hold) tick();
        chk("done_wait_core", 32'(done), 0);
        chk("busy_wait_core", 32'(busy), 1);
        core_busy = 1'b0;
        irq_clr   = clr_same;
        tick();
        irq_clr = 1'b0;
        chk("done_set", 32'(done), 1);
        chk("irq_on_done", 32'(irq), 1);
        chk("busy_clear_done", 32'(busy), 0);
        chk("err_none_done", 32'(err), 0);
    endtask

    task automatic abort_job(input int n, input int j, input bit with_final);
        int left;
        left = n;
        send_sets(j, left);
        abort    = 1'b1;
        set_done = with_final;
        tick();
        abort    = 1'b0;
        set_done = 1'b0;
        core_busy = 1'b0;
        chk("err_abort", 32'(err), 3);
        chk("done_abort", 32'(done), 0);
        chk("irq_abort", 32'(irq), 1);
        chk("core_abort_pulse", 32'(core_abort), 1);
        chk("sets_abort", 32'(sets_left), 0);
        chk("busy_abort", 32'(busy), 0);
        tick();
        chk("core_abort_single", 32'(core_abort), 0);
    endtask

    task automatic bad_job(input int h, input int w, input int deg);
        int seen;
        drive_cfg(h, w, deg, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_badcfg", 32'(err), 1);
        chk("irq_badcfg", 32'(irq), 1);
        chk("done_badcfg", 32'(done), 0);
        seen = 0;
        if (busy) seen++;
        repeat (20) begin
            tick();
            if (busy || core_start) seen++;
        end
        chk("badcfg_no_run", 32'(seen), 0);
    endtask

    task automatic clear_irq;
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("irq_cleared", 32'(irq), 0);
    endtask

    initial begin
        int h, w, n, mode, seen;

        // Reset
        @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_sets", 32'(sets_left), 0);
        chk("rst_core_start", 32'(core_start), 0);
        rst_n = 1'b1;
        tick();

        // Basic job and the ceil rounding of set counts
        start_job(16, 16, 1, 0);
        finish_job(4, 1'b0);
        start_job(17, 9, 2, 1);
        finish_job(6, 1'b1);          // clear together with completion: stays set
        clear_irq();

        // Largest legal image, second start while busy, then abort
        start_job(32767, 16383, 3, 1);
        drive_cfg(8, 8, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        repeat (5) begin
            tick();
            if (core_start) seen++;
        end
        chk("restart_ignored_start", 32'(seen), 0);
        chk("restart_ignored_h", 32'(core_h), 32767);
        chk("restart_ignored_sets", 32'(sets_left), 8388608);
        chk("restart_ignored_busy", 32'(busy), 1);
        abort_job(8388608, 0, 1'b0);

        // Start+abort and abort alone in IDLE are ignored
        drive_cfg(8, 8, 0, 0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 0);
        chk("idle_abort_err", 32'(err), 3);
        chk("idle_abort_pulse", 32'(core_abort), 0);

        // Rejected configurations
        bad_job(0, 16, 0);
        bad_job(16, 16384, 1);
        bad_job(16, 16, 5);
        bad_job(32768, 8, 2);
        clear_irq();

        // Watchdog: 14 stalled cycles survive, 15 fire
        start_job(24, 24, 0, 0);
        dma_ready = 1'b0;
        repeat (14) tick();
        chk("wd14_err", 32'(err), 0);
        chk("wd14_busy", 32'(busy), 1);
        dma_ready = 1'b1;
        tick();
        dma_ready = 1'b0;
        repeat (14) tick();
        chk("wd_rearm_busy", 32'(busy), 1);
        tick();
        dma_ready = 1'b1;
        core_busy = 1'b0;
        chk("wd_err", 32'(err), 2);
        chk("wd_core_abort", 32'(core_abort), 1);
        chk("wd_irq", 32'(irq), 1);
        chk("wd_busy", 32'(busy), 0);
        clear_irq();

        // Abort in the same cycle as the final set
        start_job(8, 24, 1, 1);
        abort_job(3, 2, 1'b1);

        // Randomized jobs
        for (int it = 0; it < 10; it++) begin
            h    = $urandom_range(1, 40);
            w    = $urandom_range(1, 40);
            n    = exp_sets(h, w);
            mode = $urandom_range(0, 2);
            if (mode == 2) begin
                int wait_c;
                drive_cfg(h, w, $urandom_range(0, 3), $urandom_range(0, 1));
                start = 1'b1;
                tick();
                start = 1'b0;
                wait_c = $urandom_range(0, 10);
                repeat (wait_c) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("calc_abort_err", 32'(err), 3);
                chk("calc_abort_busy", 32'(busy), 0);
                seen = 0;
                repeat (20) begin
                    tick();
                    if (core_start) seen++;
                end
                chk("calc_abort_no_start", 32'(seen), 0);
            end else begin
                start_job(h, w, $urandom_range(0, 3), $urandom_range(0, 1));
                if (mode == 0) finish_job(n, 1'($urandom_range(0, 1)));
                else abort_job(n, $urandom_range(0, n - 1), 1'b0);
            end
            if (!exp_valid(h, w, 0)) chk("model_range", 32'(h), 0);
        end

        // Asynchronous reset in the middle of a job
        start_job(16, 24, 2, 1);
        set_done = 1'b1;
        tick();
        set_done = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_sets", 32'(sets_left), 0);
        chk("arst_irq", 32'(irq), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_core_h", 32'(core_h), 0);
        chk("arst_core_deg", 32'(core_deg), 0);
        chk("arst_core_dir", 32'(core_dir), 0);
        #1;
        rst_n = 1'b1;
        core_busy = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rot_job_ctrl.md
Name: rot_job_ctrl

Overview:
Job-level sequencer for the rotate engine. It accepts a configuration and start request from the register interface and validates the image limits. It computes the total number of 8x8 pixel sets, launches the core and counts set completions. It also supervises DMA stalls, handles abort and raises a sticky interrupt with completion or error status. It sits between the register slave and core_set.

Parameters:
TIMEOUT_W, 16, width of the DMA-stall watchdog counter; a timeout fires after 2^TIMEOUT_W-1 consecutive not-ready cycles.
SETS_W, 24, width of the set counter; this covers the maximum of 4096*2048 sets.

Ports:
I_HCLK  in  1  clock
I_HRESET_N  in  1  reset, asynchronous, active-low
I_CFG_HEIGHT  in  16  image height in pixels
I_CFG_WIDTH  in  16  image width in pixels
I_CFG_DIRECTION  in  1  rotation direction
I_CFG_DEGREES  in  3  rotation code, 0..3 valid
I_CFG_START  in  1  start request pulse
I_CFG_ABORT  in  1  abort request pulse
I_IRQ_CLR  in  1  interrupt clear pulse
I_CORE_BUSY  in  1  core not in IDLE
I_CORE_SET_DONE  in  1  one-cycle pulse per 8x8 set written back
I_DMA_READY  in  1  DMA ready, same signal the core sees
O_CORE_START  out  1  one-cycle launch pulse to the core
O_CORE_HEIGHT  out  16  latched height
O_CORE_WIDTH  out  16  latched width
O_CORE_DIRECTION  out  1  latched direction
O_CORE_DEGREES  out  3  latched degrees
O_CORE_ABORT  out  1  one-cycle pulse forcing the core to IDLE
O_BUSY  out  1  job in progress
O_DONE  out  1  sticky: last job completed
O_ERR  out  2  sticky: 0 none, 1 BADCFG, 2 TIMEOUT, 3 ABORTED
O_IRQ  out  1  sticky interrupt
O_SETS_LEFT  out  SETS_W  sets remaining

Behaviour:
- Reset: I_HRESET_N low forces all outputs and registers to 0 and the state to IDLE, immediately and asynchronously. This applies mid-job as well; the core sees the same reset.
- States: IDLE, CALC, LAUNCH, RUN, FINISH.
- IDLE, on I_CFG_START=1 with I_CFG_ABORT=0:
  - Clear O_DONE and O_ERR.
  - Latch all configuration into the O_CORE_* outputs.
  - Check the configuration. It is invalid if H==0, W==0, H[15]=1, W[15:14]!=0, or DEGREES>3.
  - Invalid: O_ERR=1, O_IRQ=1, stay in IDLE, O_BUSY stays 0.
  - Valid: go to CALC, O_BUSY=1.
- Set counts: hsets=(H+7)>>3 (13 bits) and wsets=(W+7)>>3 (12 bits). Both are computed from the latched values.
- CALC:
  - Issue a GO pulse to the multiplier in the first cycle.
  - Wait for multiplier valid, exactly 12 cycles later.
  - Load O_SETS_LEFT = hsets*wsets, then go to LAUNCH.
- LAUNCH: O_CORE_START=1 for one cycle, then go to RUN.
- Start latency: start sampled at edge 0 → O_BUSY=1 after edge 0 → O_CORE_START=1 after edge 13, for one cycle.
- RUN:
  - Each I_CORE_SET_DONE decrements O_SETS_LEFT. The counter saturates at 0 and never wraps.
  - When a decrement reaches 0, go to FINISH.
- Watchdog (RUN only): counts consecutive cycles with I_DMA_READY=0 and clears to 0 on I_DMA_READY=1.
  - At all-ones: O_ERR=2, O_CORE_ABORT pulse, O_IRQ=1, O_BUSY=0, go to IDLE.
- FINISH: wait for I_CORE_BUSY=0, then set O_DONE=1 and O_IRQ=1, clear O_BUSY, go to IDLE. No timeout applies in FINISH.
- Abort: I_CFG_ABORT in CALC, LAUNCH, RUN or FINISH produces one O_CORE_ABORT pulse, O_ERR=3, O_IRQ=1, O_SETS_LEFT=0 and a return to IDLE. Abort in IDLE is ignored.
- Precedence, highest first: abort > final set completion > watchdog timeout.
- Start while O_BUSY=1 is ignored. Start together with abort in IDLE is ignored.
- O_IRQ is cleared only by I_IRQ_CLR. If a set-event and I_IRQ_CLR occur in the same cycle, the IRQ stays set.
- O_CORE_* configuration outputs hold their latched values until the next accepted start.
- All outputs are registered.

Decomposition:
- Shared package rot_pkg: state encodings, O_ERR codes (ERR_NONE, ERR_BADCFG, ERR_TIMEOUT, ERR_ABORT), limits MAX_H=32767 and MAX_W=16383, SET_DIM=8. The package is reusable by core_set.
- Sub-module rot_set_mul: sequential shift-add multiplier, 13x12 bits → 24-bit product.
  - Ports: I_HCLK, I_HRESET_N, I_GO, I_A[12:0], I_B[11:0], O_P[23:0], O_VALID.
  - O_VALID pulses 12 cycles after I_GO.

Test Plan:
- H=16, W=16, DEG=1, start → O_CORE_START after edge 13, O_SETS_LEFT=4; four I_CORE_SET_DONE then I_CORE_BUSY=0 → O_DONE=1, O_IRQ=1, O_BUSY=0.
- H=17, W=9 → O_SETS_LEFT=6. H=32767, W=16383 → O_SETS_LEFT=8388608.
- H=0, or W=16384, or DEG=5 → O_ERR=1, O_IRQ=1, O_BUSY never high, no O_CORE_START.
- TIMEOUT_W=4: RUN with I_DMA_READY=0 for 15 cycles → O_ERR=2 and an O_CORE_ABORT pulse. A 14-cycle stall followed by ready resets the watchdog with no error.
- Abort in the same cycle as the final I_CORE_SET_DONE → O_ERR=3, O_DONE=0. A second start while busy is ignored.
- Async reset mid-RUN → all outputs 0 with no clock edge. I_IRQ_CLR in the same cycle as a completion event → O_IRQ stays 1.
